// File: rtl/bcd_xs3_seq_converter_if.sv
// Handshake bundle for bcd_xs3_seq_converter: an input word channel and a result channel.
// The master modport is the producer/consumer side and the slave modport is the converter.
interface bcd_xs3_seq_converter_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_data;
  logic                  mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_data;
  logic [DIGITS-1:0]     err_mask;
  logic                  err;
  logic [7:0]            err_count;

  modport master (
    output in_valid, in_data, mode, out_ready,
    input  in_ready, out_valid, out_data, err_mask, err, err_count
  );

  modport slave (
    input  in_valid, in_data, mode, out_ready,
    output in_ready, out_valid, out_data, err_mask, err, err_count
  );
endinterface

// File: rtl/bcd_xs3_seq_converter.sv
// Sequential BCD <-> excess-3 converter that processes one digit per clock, LSD first.
// Define BCD_XS3_ERRCNT_EN to build the saturating invalid-digit counter on err_count.
module bcd_xs3_seq_converter #(
  parameter int DIGITS = 4
) (
  input  logic                    clock,
  input  logic                    reset_b,
  bcd_xs3_seq_converter_if.slave  bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [W-1:0]        src_q, src_d;
  logic                mode_q, mode_d;
  logic [W-1:0]        out_data_q, out_data_d;
  logic [DIGITS-1:0]   err_mask_q, err_mask_d;

  logic [3:0]          digit;
  logic [3:0]          conv_digit;
  logic                digit_ok;
  logic                accept;
  logic                out_hs;

  assign accept = bus.in_valid && (state_q == IDLE);
  assign out_hs = bus.out_ready && (state_q == DONE);

  // Per-digit code conversion, mod 16 with no carry into the neighbouring digit.
  always_comb begin
    digit      = src_q[4*int'(cnt_q) +: 4];
    digit_ok   = 1'b0;
    conv_digit = digit;
    if (!mode_q) begin
      digit_ok = (digit <= 4'd9);
      if (digit_ok) conv_digit = digit + 4'd3;
    end else begin
      digit_ok = (digit >= 4'd3) && (digit <= 4'd12);
      if (digit_ok) conv_digit = digit - 4'd3;
    end
  end

  // NOTE: every variable gets a default at the top so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    src_d      = src_q;
    mode_d     = mode_q;
    out_data_d = out_data_q;
    err_mask_d = err_mask_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = CONV;
          cnt_d      = '0;
          src_d      = bus.in_data;
          mode_d     = bus.mode;
          out_data_d = '0;
          err_mask_d = '0;
        end
      end
      CONV: begin
        out_data_d[4*int'(cnt_q) +: 4] = conv_digit;
        err_mask_d[int'(cnt_q)]        = ~digit_ok;
        if (cnt_q == CW'(DIGITS - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the latched source word is reset too, keeping the whole datapath deterministic after reset.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      src_q      <= '0;
      mode_q     <= 1'b0;
      out_data_q <= '0;
      err_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      src_q      <= src_d;
      mode_q     <= mode_d;
      out_data_q <= out_data_d;
      err_mask_q <= err_mask_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = out_data_q;
  assign bus.err_mask  = err_mask_q;
  assign bus.err       = |err_mask_q;

`ifdef BCD_XS3_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  int         err_sum;

  // Accumulate the flagged digits of each delivered word, saturating at 255.
  always_comb begin
    err_sum   = int'(err_cnt_q) + $countones(err_mask_q);
    err_cnt_d = err_cnt_q;
    if (out_hs) err_cnt_d = (err_sum > 255) ? 8'd255 : 8'(err_sum);
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) err_cnt_q <= 8'd0;
    else          err_cnt_q <= err_cnt_d;
  end

  assign bus.err_count = err_cnt_q;
`else
  assign bus.err_count = 8'd0;
`endif

endmodule
